// File: rtl/security_pkg.sv
// Shared types and constants for the multi-zone security sequencer.
package security_pkg;

    // Encoding is visible on the debug state output, so the values are fixed.
    typedef enum logic [2:0] {
        StDisarmed = 3'd0,
        StExit     = 3'd1,
        StArmed    = 3'd2,
        StEntry    = 3'd3,
        StAlarm    = 3'd4,
        StSilent   = 3'd5
    } state_e;

    localparam int unsigned DefaultNumZones   = 4;
    localparam int unsigned DefaultExitDelay  = 8;
    localparam int unsigned DefaultEntryDelay = 8;
    localparam int unsigned DefaultSirenTime  = 16;
    localparam int unsigned DefaultCntW       = 8;

    // The only zone that gets an entry grace period; every other zone is instant.
    localparam int unsigned EntryZone = 0;

endpackage

// File: rtl/delay_timer.sv
// Down-counter shared by the exit, entry and siren phases. Load wins over
// enable, and the count saturates at zero.
module delay_timer
    import security_pkg::*;
#(
    parameter int unsigned CntW = DefaultCntW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            en_i,
    output logic            expired_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: reload, decrement while enabled, or hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/security_sequencer.sv
// Arming and alarm sequencer: exit delay, entry delay on the entry zone,
// timed siren followed by a silent latched alarm, with per-zone bypass.
module security_sequencer
    import security_pkg::*;
#(
    parameter int unsigned NumZones   = DefaultNumZones,
    parameter int unsigned ExitDelay  = DefaultExitDelay,
    parameter int unsigned EntryDelay = DefaultEntryDelay,
    parameter int unsigned SirenTime  = DefaultSirenTime,
    parameter int unsigned CntW       = DefaultCntW
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                arm_i,
    input  logic                disarm_i,
    input  logic [NumZones-1:0] sensor_i,
    input  logic [NumZones-1:0] zone_mask_i,
    output logic                armed_o,
    output logic                exit_pending_o,
    output logic                alarm_o,
    output logic                siren_o,
    output logic [NumZones-1:0] tripped_zone_o,
    output logic [2:0]          state_o
);

    localparam logic [NumZones-1:0] EntryBit = NumZones'(1) << EntryZone;

    state_e              state_q, state_d;
    logic [NumZones-1:0] trip_q, trip_d;
    logic [NumZones-1:0] act;
    logic                inst, ent;
    logic                tmr_load, tmr_en, tmr_expired;
    logic [CntW-1:0]     tmr_val;

    assign act  = sensor_i & ~zone_mask_i;
    assign ent  = act[EntryZone];
    assign inst = |(act & ~EntryBit);

    delay_timer #(
        .CntW (CntW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    // Next-state, timer control and trip recording.
    always_comb begin
        state_d  = state_q;
        trip_d   = trip_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;

        // Trips are recorded in every state that watches the sensors.
        if (state_q inside {StArmed, StEntry, StAlarm, StSilent}) begin
            trip_d = trip_q | act;
        end

        case (state_q)
            StDisarmed: begin
                if (arm_i && !disarm_i) begin
                    state_d  = StExit;
                    trip_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(ExitDelay - 1);
                end
            end
            StExit: begin
                if (disarm_i) state_d = StDisarmed;
                else if (tmr_expired) state_d = StArmed;
                else tmr_en = 1'b1;
            end
            StArmed: begin
                if (disarm_i) begin
                    state_d = StDisarmed;
                end else if (inst) begin
                    state_d  = StAlarm;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(SirenTime - 1);
                end else if (ent) begin
                    state_d  = StEntry;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(EntryDelay - 1);
                end
            end
            StEntry: begin
                if (disarm_i) begin
                    state_d = StDisarmed;
                end else if (inst || tmr_expired) begin
                    state_d  = StAlarm;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(SirenTime - 1);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StAlarm: begin
                if (disarm_i) state_d = StDisarmed;
                else if (tmr_expired) state_d = StSilent;
                else tmr_en = 1'b1;
            end
            StSilent: begin
                if (disarm_i) begin
                    state_d = StDisarmed;
                end else if (|act) begin
                    state_d  = StAlarm;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(SirenTime - 1);
                end
            end
            default: state_d = StDisarmed;
        endcase
    end

    // State and trip registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StDisarmed;
            trip_q  <= '0;
        end else begin
            state_q <= state_d;
            trip_q  <= trip_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        armed_o        = (state_q == StArmed) || (state_q == StEntry);
        exit_pending_o = (state_q == StExit);
        alarm_o        = (state_q == StAlarm) || (state_q == StSilent);
        siren_o        = (state_q == StAlarm);
        tripped_zone_o = trip_q;
        state_o        = state_q;
    end

endmodule
